// File: rtl/mux_add_pipe_pkg.sv
// ----------------------------------------------------------------------------
// mux_add_pipe_pkg
// Shared definitions for the mux/add pipeline:
//   mode_e : selection mode encodings (indexed / priority)
//   clog2  : ceiling log2, used to size the channel-index field
// ----------------------------------------------------------------------------
package mux_add_pipe_pkg;

    typedef enum logic {
        MODE_INDEXED  = 1'b0,
        MODE_PRIORITY = 1'b1
    } mode_e;

    // Smallest r with 2**r >= n; n is expected to be >= 2.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_add_pipe_mux_sel.sv
// ----------------------------------------------------------------------------
// mux_sel
// Combinational channel selector.
//   data_in  : NCH packed channels, channel i at [i*WIDTH +: WIDTH]
//   dflt     : operand used when priority mode finds no request
//   mode     : 0 = indexed (sel low SELW bits), 1 = priority (sel bitmask)
//   sel      : index or request mask
//   opnd     : selected operand
//   ch       : index of the channel that supplied opnd (0 when dflt used)
//   use_dflt : opnd came from dflt
// ----------------------------------------------------------------------------
module mux_sel
    import mux_add_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    localparam int SELW = clog2(NCH)
) (
    input  logic [NCH*WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0]     dflt,
    input  logic                 mode,
    input  logic [NCH-1:0]       sel,
    output logic [WIDTH-1:0]     opnd,
    output logic [SELW-1:0]      ch,
    output logic                 use_dflt
);

    int idx;

    always_comb begin
        opnd     = dflt;
        ch       = '0;
        use_dflt = 1'b0;
        idx      = int'(sel[SELW-1:0]);
        // Indices past the last channel fold onto the last channel.
        if (idx > NCH - 1) idx = NCH - 1;

        if (mode == MODE_PRIORITY) begin
            use_dflt = 1'b1;
            // Ascending scan: the highest-numbered request is the last to write.
            for (int i = 0; i < NCH; i++) begin
                if (sel[i]) begin
                    opnd     = data_in[i*WIDTH +: WIDTH];
                    ch       = SELW'(i);
                    use_dflt = 1'b0;
                end
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (i == idx) begin
                    opnd = data_in[i*WIDTH +: WIDTH];
                    ch   = SELW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/mux_add_pipe.sv
// ----------------------------------------------------------------------------
// mux_add_pipe
// Two-stage valid/ready pipeline: select one of NCH channels (indexed or
// priority with default), then add t with the carry kept.
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid / in_ready   : input handshake
//   data_in, dflt, t      : channels, default operand, addend
//   mode, sel             : selection mode and index / request mask
//   out_valid / out_ready : output handshake
//   z, z_ch, z_dflt       : sum, source channel, default-used flag
//   xfer_cnt              : completed output transfers, wraps at 16 bits
// ----------------------------------------------------------------------------
module mux_add_pipe
    import mux_add_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    localparam int SELW = clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NCH*WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0]     dflt,
    input  logic [WIDTH-1:0]     t,
    input  logic                 mode,
    input  logic [NCH-1:0]       sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH:0]       z,
    output logic [SELW-1:0]      z_ch,
    output logic                 z_dflt,
    output logic [15:0]          xfer_cnt
);

    function automatic logic [WIDTH:0] add_ext(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    logic [WIDTH-1:0] sel_opnd;
    logic [SELW-1:0]  sel_ch;
    logic             sel_dflt;

    logic             vld_p1;
    logic [WIDTH-1:0] opnd_p1;
    logic [WIDTH-1:0] t_p1;
    logic [SELW-1:0]  ch_p1;
    logic             dflt_p1;

    logic             vld_p2;
    logic [WIDTH:0]   z_p2;
    logic [SELW-1:0]  ch_p2;
    logic             dflt_p2;

    logic             adv;

    // Both stages move together whenever the output slot can take data.
    assign adv      = !vld_p2 || out_ready;
    assign in_ready = !vld_p1 || adv;

    mux_sel #(
        .WIDTH (WIDTH),
        .NCH   (NCH)
    ) u_mux_sel (
        .data_in  (data_in),
        .dflt     (dflt),
        .mode     (mode),
        .sel      (sel),
        .opnd     (sel_opnd),
        .ch       (sel_ch),
        .use_dflt (sel_dflt)
    );

    // ---- S1: selected operand, addend and tags ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (in_ready) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_ready && in_valid) begin
            opnd_p1 <= sel_opnd;
            t_p1    <= t;
            ch_p1   <= sel_ch;
            dflt_p1 <= sel_dflt;
        end
    end

    // ---- S2: sum and tags, held while the consumer stalls ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2   <= 1'b0;
            z_p2     <= '0;
            ch_p2    <= '0;
            dflt_p2  <= 1'b0;
            xfer_cnt <= '0;
        end else begin
            if (adv) vld_p2 <= vld_p1;
            if (adv && vld_p1) begin
                z_p2    <= add_ext(opnd_p1, t_p1);
                ch_p2   <= ch_p1;
                dflt_p2 <= dflt_p1;
            end
            if (vld_p2 && out_ready) xfer_cnt <= xfer_cnt + 16'd1;
        end
    end

    assign out_valid = vld_p2;
    assign z         = z_p2;
    assign z_ch      = ch_p2;
    assign z_dflt    = dflt_p2;

endmodule

// File: tb/tb_mux_add_pipe.sv
// ----------------------------------------------------------------------------
// tb_mux_add_pipe
// Self-checking bench for mux_add_pipe: a vector table for single
// transactions on a WIDTH=8/NCH=4 instance, a NCH=5 instance for index
// folding, plus sequences for backpressure, mid-flight reset and counter wrap.
// ----------------------------------------------------------------------------
module tb_mux_add_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // NCH=4 instance
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] data_in = {8'hFF, 8'h30, 8'h20, 8'h10};
    logic [7:0]  dflt = 8'h00;
    logic [7:0]  t = 8'h00;
    logic        mode = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [8:0]  z;
    logic [1:0]  z_ch;
    logic        z_dflt;
    logic [15:0] xfer_cnt;

    // NCH=5 instance
    logic        in_valid5 = 1'b0;
    logic        in_ready5;
    logic [39:0] data_in5 = {8'h44, 8'hFF, 8'h30, 8'h20, 8'h10};
    logic [7:0]  dflt5 = 8'h00;
    logic [7:0]  t5 = 8'h00;
    logic        mode5 = 1'b0;
    logic [4:0]  sel5 = 5'h0;
    logic        out_valid5;
    logic        out_ready5 = 1'b1;
    logic [8:0]  z5;
    logic [2:0]  z_ch5;
    logic        z_dflt5;
    logic [15:0] xfer_cnt5;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux_add_pipe #(.WIDTH(8), .NCH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .dflt(dflt), .t(t), .mode(mode), .sel(sel),
        .out_valid(out_valid), .out_ready(out_ready), .z(z), .z_ch(z_ch),
        .z_dflt(z_dflt), .xfer_cnt(xfer_cnt)
    );

    mux_add_pipe #(.WIDTH(8), .NCH(5)) dut5 (
        .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5),
        .data_in(data_in5), .dflt(dflt5), .t(t5), .mode(mode5), .sel(sel5),
        .out_valid(out_valid5), .out_ready(out_ready5), .z(z5), .z_ch(z_ch5),
        .z_dflt(z_dflt5), .xfer_cnt(xfer_cnt5)
    );

    typedef struct {
        string      name;
        logic       mode;
        logic [3:0] sel;
        logic [7:0] t;
        logic [7:0] dflt;
        logic [8:0] exp_z;
        logic [1:0] exp_ch;
        logic       exp_dflt;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One transaction, consumer always ready; checks latency and result.
    task automatic send_check(input vec_t v);
        int lat;
        @(negedge clk);
        mode = v.mode; sel = v.sel; t = v.t; dflt = v.dflt;
        in_valid = 1'b1; out_ready = 1'b1;
        #1 chk({v.name, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        // Scramble inputs after acceptance; the queued result must not change.
        in_valid = 1'b0; mode = ~v.mode; sel = 4'hF; t = 8'hAA; dflt = 8'h55;
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({v.name, "_latency"}, 32'(lat), 32'd2);
        chk({v.name, "_z"}, 32'(z), 32'(v.exp_z));
        chk({v.name, "_z_ch"}, 32'(z_ch), 32'(v.exp_ch));
        chk({v.name, "_z_dflt"}, 32'(z_dflt), 32'(v.exp_dflt));
        @(negedge clk);
    endtask

    // Send n transactions with the consumer always ready, then drain.
    task automatic stream(input int n, input logic [15:0] exp_cnt, input string nm);
        int acc, rcv, cyc;
        acc = 0; rcv = 0; cyc = 0;
        mode = 1'b0; sel = 4'h0; t = 8'h00; out_ready = 1'b1;
        while (rcv < n && cyc < n + 20) begin
            @(negedge clk);
            in_valid = (acc < n);
            #1;
            if (in_valid && in_ready) acc++;
            if (out_valid && out_ready) rcv++;
            cyc++;
        end
        in_valid = 1'b0;
        chk({nm, "_received"}, 32'(rcv), 32'(n));
        @(negedge clk);
        chk({nm, "_xfer_cnt"}, 32'(xfer_cnt), 32'(exp_cnt));
    endtask

    initial begin
        logic [7:0] chv[4];
        logic [8:0] exp_bp[10];
        int         sent, rcv, cyc;
        logic       hold, saw_block, seen;
        logic [8:0] held_z;
        logic [1:0] held_ch;
        int         lat;

        chv[0] = 8'h10; chv[1] = 8'h20; chv[2] = 8'h30; chv[3] = 8'hFF;

        vecs[0] = '{"idx_sel3",   1'b0, 4'd3,    8'h01, 8'h00, 9'h100, 2'd3, 1'b0};
        vecs[1] = '{"pri_0110",   1'b1, 4'b0110, 8'h05, 8'h00, 9'h035, 2'd2, 1'b0};
        vecs[2] = '{"pri_none",   1'b1, 4'b0000, 8'h01, 8'h7F, 9'h080, 2'd0, 1'b1};
        vecs[3] = '{"idx_sel7",   1'b0, 4'd7,    8'h00, 8'h00, 9'h0FF, 2'd3, 1'b0};
        vecs[4] = '{"idx_sel0",   1'b0, 4'd0,    8'hFF, 8'h00, 9'h10F, 2'd0, 1'b0};
        vecs[5] = '{"pri_1000",   1'b1, 4'b1000, 8'h02, 8'h00, 9'h101, 2'd3, 1'b0};
        vecs[6] = '{"pri_0001",   1'b1, 4'b0001, 8'h00, 8'h99, 9'h010, 2'd0, 1'b0};
        vecs[7] = '{"idx_sel1",   1'b0, 4'd1,    8'h80, 8'h00, 9'h0A0, 2'd1, 1'b0};
        vecs[8] = '{"pri_1111",   1'b1, 4'b1111, 8'hFF, 8'h00, 9'h1FE, 2'd3, 1'b0};
        vecs[9] = '{"idx_sel2",   1'b0, 4'd2,    8'h10, 8'h00, 9'h040, 2'd2, 1'b0};

        // Reset state while rst is held.
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_z", 32'(z), 32'd0);
        chk("rst_z_ch", 32'(z_ch), 32'd0);
        chk("rst_z_dflt", 32'(z_dflt), 32'd0);
        chk("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 10; i++) send_check(vecs[i]);
        chk("table_xfer_cnt", 32'(xfer_cnt), 32'd10);

        // NCH=5: out-of-range indices fold onto channel 4.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            mode5 = 1'b0; sel5 = (k == 0) ? 5'd6 : 5'd7; t5 = 8'h01; in_valid5 = 1'b1;
            @(posedge clk);
            #1 in_valid5 = 1'b0; sel5 = 5'd0;
            lat = 0;
            while (!out_valid5 && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            chk("nch5_latency", 32'(lat), 32'd2);
            chk("nch5_z", 32'(z5), 32'h045);
            chk("nch5_z_ch", 32'(z_ch5), 32'd4);
            chk("nch5_z_dflt", 32'(z_dflt5), 32'd0);
            @(negedge clk);
        end

        // Backpressure: 10 back-to-back inputs, consumer stalls 3 cycles.
        pulse_rst();
        for (int i = 0; i < 10; i++) exp_bp[i] = {1'b0, chv[i % 4]} + 9'(i);
        sent = 0; rcv = 0; cyc = 0; hold = 1'b0; saw_block = 1'b0;
        held_z = '0; held_ch = '0;
        while (rcv < 10 && cyc < 60) begin
            @(negedge clk);
            in_valid = (sent < 10);
            mode = 1'b0; sel = 4'(sent % 4); t = 8'(sent);
            out_ready = !(cyc >= 4 && cyc < 7);
            #1;
            if (hold && out_valid) begin
                chk("bp_hold_z", 32'(z), 32'(held_z));
                chk("bp_hold_ch", 32'(z_ch), 32'(held_ch));
            end
            if (in_valid && !in_ready) saw_block = 1'b1;
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                chk("bp_z", 32'(z), 32'(exp_bp[rcv]));
                chk("bp_z_ch", 32'(z_ch), 32'(rcv % 4));
                rcv++;
            end
            hold = out_valid && !out_ready;
            held_z = z; held_ch = z_ch;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_received", 32'(rcv), 32'd10);
        chk("bp_in_ready_dropped", 32'(saw_block), 32'd1);
        @(negedge clk);
        chk("bp_xfer_cnt", 32'(xfer_cnt), 32'd10);

        // Reset with two transactions in flight.
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b0; mode = 1'b0; sel = 4'd1; t = 8'h00;
        @(negedge clk);
        sel = 4'd2;
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("inflight_out_valid", 32'(out_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_xfer_cnt", 32'(xfer_cnt), 32'd0);
        chk("midrst_z", 32'(z), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1 chk("midrst_release_in_ready", 32'(in_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("midrst_no_ghost", 32'(seen), 32'd0);
        chk("midrst_cnt_after", 32'(xfer_cnt), 32'd0);

        // Counter wrap: bring it to 0xFFFE, then three more transfers.
        stream(65534, 16'hFFFE, "wrap_pre");
        stream(3, 16'h0001, "wrap_post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
